// File: rtl/snake_dir_queue.sv
// Snake direction controller: button edge capture, pending-turn FIFO, reversal blocking.
// Optional SNAKE_DIR_BYPASS_EN: an accepted turn on an empty-FIFO tick applies at once.
module snake_dir_queue #(
   parameter int QDEPTH = 2,
   parameter int LEN_W  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         btn_up,
   input  logic                         btn_down,
   input  logic                         btn_left,
   input  logic                         btn_right,
   input  logic                         tick,
   input  logic [LEN_W-1:0]             len,
   output logic [1:0]                   dir,
   output logic [$clog2(QDEPTH+1)-1:0]  q_count,
   output logic                         dropped,
   output logic                         rev_blocked
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   logic [3:0]    btn;
   logic [3:0]    prev;
   logic [3:0]    rise;
   logic          cmd_valid;
   logic [1:0]    cmd;
   logic [1:0]    ref_dir;
   logic [1:0]    mem [QDEPTH];
   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr;
   logic [PW-1:0] tail;
   logic          empty;
   logic          full;
   logic          is_rev;
   logic          accept;
   logic          pop;
   logic          bypass;
   logic          push;
   logic          drop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign btn  = {btn_up, btn_down, btn_left, btn_right};
   assign rise = btn & ~prev;

   // Priority up > down > left > right; lower-priority rises are discarded
   always_comb begin
      cmd_valid = 1'b1;
      cmd       = 2'b00;
      if (rise[3])      cmd = 2'b11;
      else if (rise[2]) cmd = 2'b01;
      else if (rise[1]) cmd = 2'b10;
      else if (rise[0]) cmd = 2'b00;
      else              cmd_valid = 1'b0;
   end

   assign empty   = (q_count == '0);
   assign full    = (q_count == CW'(QDEPTH));
   assign tail    = (wptr == '0) ? PW'(QDEPTH - 1) : wptr - 1'b1;
   assign ref_dir = empty ? dir : mem[tail];

   // Length 0 or 1 behaves as a single segment, which may reverse
   assign is_rev = (cmd == (ref_dir ^ 2'b10)) && (len > LEN_W'(1));
   assign accept = cmd_valid && (cmd != ref_dir) && !is_rev;
   assign pop    = tick && !empty;

`ifdef SNAKE_DIR_BYPASS_EN
   assign bypass = accept && tick && empty;
`else
   assign bypass = 1'b0;
`endif

   assign push = accept && !bypass && (!full || pop);
   assign drop = accept && !bypass && full && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= cmd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev        <= 4'b1111;
         dir         <= 2'b00;
         rptr        <= '0;
         wptr        <= '0;
         q_count     <= '0;
         dropped     <= 1'b0;
         rev_blocked <= 1'b0;
      end else begin
         prev        <= btn;
         dropped     <= drop;
         rev_blocked <= cmd_valid && is_rev;
         if (pop) begin
            dir  <= mem[rptr];
            rptr <= inc(rptr);
         end else if (bypass) begin
            dir <= cmd;
         end
         if (push) wptr <= inc(wptr);
         if (push && !pop)      q_count <= q_count + 1'b1;
         else if (pop && !push) q_count <= q_count - 1'b1;
      end
   end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Directed bench for snake_dir_queue (QDEPTH=2, LEN_W=8).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_snake_dir_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic       tick;
   logic [7:0] len;
   logic [1:0] dir;
   logic [1:0] q_count;
   logic       dropped;
   logic       rev_blocked;
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   snake_dir_queue #(.QDEPTH(2), .LEN_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .btn_up(btn[3]),
      .btn_down(btn[2]),
      .btn_left(btn[1]),
      .btn_right(btn[0]),
      .tick(tick),
      .len(len),
      .dir(dir),
      .q_count(q_count),
      .dropped(dropped),
      .rev_blocked(rev_blocked)
   );

   localparam logic [3:0] UP = 4'b1000, DOWN = 4'b0100, LEFT = 4'b0010;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; btn = '0; tick = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic press(input logic [3:0] b);
      btn = b;
      cyc();
      btn = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn = '0; tick = 1'b0; len = 8'd4;
      cyc(); cyc();
      rst = 1'b0;
      n_vec++;
      if (dir !== 2'b00 || q_count !== 2'd0 || dropped !== 1'b0 || rev_blocked !== 1'b0) begin
         $display("FAIL reset_state dir=%0d q=%0d drop=%0d rev=%0d want 0 0 0 0",
                  dir, q_count, dropped, rev_blocked);
         n_err++;
      end
      tick = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_vec++;
         if (dir !== 2'b00 || q_count !== 2'd0) begin
            $display("FAIL idle_tick%0d dir=%0d q=%0d want 0 0", i, dir, q_count);
            n_err++;
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_turns();
      do_reset();
      len = 8'd4;
      press(UP);
      n_vec++;
      if (q_count !== 2'd1) begin
         $display("FAIL turn_q1 got %0d want 1", q_count); n_err++;
      end
      cyc();
      press(LEFT);
      n_vec++;
      if (q_count !== 2'd2 || rev_blocked !== 1'b0) begin
         $display("FAIL turn_q2 q=%0d rev=%0d want 2 0", q_count, rev_blocked); n_err++;
      end
      tick = 1'b1;
      cyc();
      n_vec++;
      if (dir !== 2'b11 || q_count !== 2'd1) begin
         $display("FAIL turn_tick1 dir=%0d q=%0d want 3 1", dir, q_count); n_err++;
      end
      cyc();
      tick = 1'b0;
      n_vec++;
      if (dir !== 2'b10 || q_count !== 2'd0 || rev_blocked !== 1'b0) begin
         $display("FAIL turn_tick2 dir=%0d q=%0d rev=%0d want 2 0 0",
                  dir, q_count, rev_blocked);
         n_err++;
      end
   endtask

   task automatic test_reverse();
      do_reset();
      len = 8'd4;
      press(LEFT);
      n_vec++;
      if (rev_blocked !== 1'b1 || q_count !== 2'd0) begin
         $display("FAIL rev_block rev=%0d q=%0d want 1 0", rev_blocked, q_count); n_err++;
      end
      cyc();
      n_vec++;
      if (rev_blocked !== 1'b0) begin
         $display("FAIL rev_pulse got %0d want 0", rev_blocked); n_err++;
      end
      len = 8'd1;
      press(LEFT);
      n_vec++;
      if (rev_blocked !== 1'b0 || q_count !== 2'd1) begin
         $display("FAIL rev_len1 rev=%0d q=%0d want 0 1", rev_blocked, q_count); n_err++;
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      n_vec++;
      if (dir !== 2'b10 || q_count !== 2'd0) begin
         $display("FAIL rev_len1_tick dir=%0d q=%0d want 2 0", dir, q_count); n_err++;
      end
   endtask

   task automatic test_overflow();
      do_reset();
      len = 8'd4;
      press(DOWN);
      press(LEFT);
      n_vec++;
      if (q_count !== 2'd2 || dropped !== 1'b0) begin
         $display("FAIL ovf_fill q=%0d drop=%0d want 2 0", q_count, dropped); n_err++;
      end
      press(UP);
      n_vec++;
      if (q_count !== 2'd2 || dropped !== 1'b1) begin
         $display("FAIL ovf_drop q=%0d drop=%0d want 2 1", q_count, dropped); n_err++;
      end
      cyc();
      n_vec++;
      if (dropped !== 1'b0) begin
         $display("FAIL ovf_pulse got %0d want 0", dropped); n_err++;
      end
      do_reset();
      press(DOWN);
      press(LEFT);
      tick = 1'b1;
      press(UP);
      tick = 1'b0;
      n_vec++;
      if (q_count !== 2'd2 || dropped !== 1'b0 || dir !== 2'b01) begin
         $display("FAIL ovf_pushpop q=%0d drop=%0d dir=%0d want 2 0 1",
                  q_count, dropped, dir);
         n_err++;
      end
      tick = 1'b1;
      cyc(); cyc();
      tick = 1'b0;
      n_vec++;
      if (dir !== 2'b11 || q_count !== 2'd0) begin
         $display("FAIL ovf_drain dir=%0d q=%0d want 3 0", dir, q_count); n_err++;
      end
   endtask

   task automatic test_hold_reset();
      len = 8'd4; tick = 1'b0;
      rst = 1'b1; btn = UP;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_vec++;
         if (q_count !== 2'd0) begin
            $display("FAIL hold_q%0d got %0d want 0", i, q_count); n_err++;
         end
      end
      btn = '0;
      cyc();
      press(UP);
      n_vec++;
      if (q_count !== 2'd1) begin
         $display("FAIL hold_repress got %0d want 1", q_count); n_err++;
      end
   endtask

   task automatic test_tick_coincident();
      do_reset();
      len = 8'd4;
      tick = 1'b1;
      press(DOWN);
      tick = 1'b0;
      n_vec++;
`ifdef SNAKE_DIR_BYPASS_EN
      if (dir !== 2'b01 || q_count !== 2'd0) begin
         $display("FAIL bypass dir=%0d q=%0d want 1 0", dir, q_count); n_err++;
      end
`else
      if (dir !== 2'b00 || q_count !== 2'd1) begin
         $display("FAIL coincident dir=%0d q=%0d want 0 1", dir, q_count); n_err++;
      end
`endif
   endtask

   initial begin
      rst = 1'b1; btn = '0; tick = 1'b0; len = 8'd4;
      test_reset();
      test_turns();
      test_reverse();
      test_overflow();
      test_hold_reset();
      test_tick_coincident();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
